uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, setting the number of byte requesters sharing one UART transmitter (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, setting the byte width.
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 16, setting the maximum cycles to wait for transmitter busy after a load.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-007 The block SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready  output  NUM_REQ  one-hot accept strobe; a byte transfers when valid and ready are both high at a rising edge.
REQ-009 The block SHALL have port tx_p_data  output  DATA_WIDTH  byte to the transmitter p_data.
REQ-010 The block SHALL have port tx_data_valid  output  1  one-cycle load strobe to the transmitter data_valid.
REQ-011 The block SHALL have port tx_busy  input  1  transmitter busy.
REQ-012 The block SHALL have port tx_done  input  1  transmitter frame-done pulse (uart_tx_done).
REQ-013 The block SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester owning the current frame.
REQ-014 The block SHALL have port active  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port err_timeout  output  1  sticky flag for a missed busy.
REQ-016 The block SHALL have port err_clr  input  1  synchronous clear of err_timeout.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-018 In IDLE with any req_valid high, req_ready SHALL be driven combinationally high for exactly one winner, chosen round-robin from (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-019 On the handshake edge, the block SHALL register the winner's byte into tx_p_data, the winner index into grant_id and last_grant, and enter LOAD.
REQ-020 In LOAD, tx_data_valid SHALL be high for exactly one cycle, and the next state SHALL be WAIT_BUSY; latency from handshake edge to tx_data_valid high is one cycle.
REQ-021 In WAIT_BUSY, tx_busy=1 SHALL move to WAIT_DONE; tx_done=1 SHALL move to IDLE (short frame, done wins over busy if both high).
REQ-022 In WAIT_BUSY, a 0-to-BUSY_TIMEOUT cycle counter SHALL run, and reaching BUSY_TIMEOUT with neither input seen SHALL set err_timeout and return to IDLE.
REQ-023 In WAIT_DONE, tx_done=1 SHALL return to IDLE; the next grant may occur in that IDLE cycle, so the back-to-back gap is one IDLE cycle plus the LOAD cycle.
REQ-024 req_ready SHALL be all-zero outside IDLE, and req_valid changes outside IDLE SHALL be ignored.
REQ-025 tx_p_data SHALL hold its value from the handshake until the next handshake.
REQ-026 When err_clr and a timeout occur in the same cycle, the set SHALL win.
REQ-027 A requester dropping req_valid before a handshake SHALL lose nothing, and the arbiter SHALL re-evaluate every IDLE cycle.
REQ-028 With a single requester active continuously, that requester SHALL be granted every frame with no starvation.

Reset
REQ-029 Asserting rst low SHALL immediately force: state IDLE; tx_data_valid 0; req_ready 0; tx_p_data 0; grant_id 0; last_grant NUM_REQ-1 (requester 0 wins first); timeout counter 0; err_timeout 0; active 0.
REQ-030 Reset mid-frame SHALL abandon the frame without issuing tx_data_valid, and the first post-reset grant SHALL again start at requester 0.

Structure
REQ-031 A shared package uart_tx_arb_pkg SHALL hold the state encodings and the default NUM_REQ, DATA_WIDTH and BUSY_TIMEOUT constants.
REQ-032 The round-robin pick SHALL live in one combinational sub-module rr_arbiter, with inputs req and last_grant and outputs one-hot grant and index.

Verification (uart_tx with CLKS_PER_BIT=3, 30-cycle frame)
REQ-033 Reset check: hold rst=0 for 20 cycles with random req_valid and data -> req_ready=0, tx_data_valid=0, tx_out=1 every cycle.
REQ-034 Single byte: req_valid=4'b0010, byte 8'hA5 -> req_ready[1] for one cycle, tx_data_valid one cycle later, grant_id=1, serial frame 0,A5 LSB-first,1, active drops one cycle after tx_done.
REQ-035 Fairness: all four valid continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0 and transmitted bytes match that order.
REQ-036 Timeout: tx_busy and tx_done tied 0 -> err_timeout=1 exactly 16 cycles after WAIT_BUSY entry, then return to IDLE; err_clr pulse clears it.
REQ-037 Mid-frame reset: rst=0 at cycle 12 of a frame -> all outputs at reset values immediately, and the next grant goes to requester 0.
REQ-038 Sweep: requester 3 sends bytes 0..255 back-to-back -> every byte received intact, with exactly 2 cycles between tx_done and the next tx_data_valid.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM encoding and default sizing for the UART transmit arbiter.
package uart_tx_arb_pkg;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] k;

    // Walk offsets from farthest to nearest so the nearest requester overwrites any earlier hit.
    always_comb begin
        grant = '0;
        index = '0;
        k     = '0;
        for (int i = N; i >= 1; i--) begin
            k = IW'((int'(last_grant) + i) % N);
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                index    = k;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources, one frame at a time,
// with a watchdog flag for a transmitter that never reports busy.
module uart_tx_arbiter import uart_tx_arb_pkg::*; #(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          err_timeout,
    input  logic                          err_clr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         grant_id_q, grant_id_d, last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  dv_q, dv_d, active_q, active_d, err_q, err_d;
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         pick;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .index      (pick)
    );

    // Gated by reset so no strobe escapes while the block is held in reset.
    assign req_ready     = (rst && state_q == IDLE) ? grant : '0;
    assign tx_p_data     = p_data_q;
    assign tx_data_valid = dv_q;
    assign grant_id      = grant_id_q;
    assign active        = active_q;
    assign err_timeout   = err_q;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        p_data_d     = p_data_q;
        cnt_d        = '0;
        err_d        = err_clr ? 1'b0 : err_q;
        case (state_q)
            IDLE: if (|req_ready) begin
                state_d      = LOAD;
                grant_id_d   = pick;
                last_grant_d = pick;
                p_data_d     = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
            end
            LOAD: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_done) state_d = IDLE;
                else if (tx_busy) state_d = WAIT_DONE;
                else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
                else cnt_d = cnt_q + 1'b1;
            end
            WAIT_DONE: if (tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dv_d     = state_d == LOAD;
        active_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            p_data_q     <= '0;
            cnt_q        <= '0;
            dv_q         <= 1'b0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            p_data_q     <= p_data_d;
            cnt_q        <= cnt_d;
            dv_q         <= dv_d;
            active_q     <= active_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a frame-level model,
// driving a behavioural 30-cycle UART transmitter (3 clocks per bit).
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_p_data;
    logic           tx_data_valid, tx_busy, tx_done, active, err_timeout;
    logic           err_clr = 1'b0;
    logic [1:0]     grant_id;
    int             total = 0;
    int             bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .grant_id      (grant_id),
        .active        (active),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    // Transmitter model. xmode 0: normal frame, 1: dead (never busy/done), 2: busy and done together.
    logic [1:0] xmode = 2'd0;
    logic       m_busy, m_done, tx_out;
    logic [9:0] m_sh;
    int         m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_sh   <= '1;
        end else begin
            m_done <= 1'b0;
            if (xmode == 2'd2) begin
                m_busy <= tx_data_valid;
                m_done <= tx_data_valid;
            end else if (xmode == 2'd0 && tx_data_valid && !m_busy) begin
                m_sh   <= {1'b1, tx_p_data, 1'b0};
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end else if (m_busy) begin
                if (m_cnt == 29) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else m_cnt <= m_cnt + 1;
            end
        end
    end

    assign tx_busy = m_busy;
    assign tx_done = m_done;
    assign tx_out  = m_busy ? m_sh[m_cnt/3] : 1'b1;

    // Winner = valid requester at the smallest forward distance past the last grant.
    function automatic int rr_pick(logic [N-1:0] v, int last);
        int best = -1;
        int bd = N;
        for (int k = 0; k < N; k++)
            if (v[k] && ((k - last - 1 + 2 * N) % N) < bd) begin
                bd = (k - last - 1 + 2 * N) % N;
                best = k;
            end
        return best;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        xmode = 2'd0;
        req_valid = '0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = N'($urandom);
            req_data = $urandom;
            #1;
            total++;
            if (req_ready !== '0 || tx_data_valid !== 1'b0 || tx_out !== 1'b1 || active !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d ready=%b dv=%b tx_out=%b active=%b (want 0,0,1,0)",
                         i, req_ready, tx_data_valid, tx_out, active);
            end
        end
        total++;
        if (tx_p_data !== '0 || grant_id !== '0 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs p_data=%h gid=%0d err=%b (want 0,0,0)", tx_p_data, grant_id, err_timeout);
        end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_single_byte;
        int n = 0;
        do_reset();
        req_data = $urandom;
        req_data[15:8] = 8'hA5;
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL single_ready got=%b want=0010", req_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (tx_data_valid !== 1'b1 || grant_id !== 2'd1 || tx_p_data !== 8'hA5 || req_ready !== '0) begin
            bad++;
            $display("FAIL single_load dv=%b gid=%0d data=%h ready=%b (want 1,1,a5,0000)",
                     tx_data_valid, grant_id, tx_p_data, req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        #1;
        total++;
        if (tx_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_dv_pulse got=%b want=0", tx_data_valid);
        end
        while (tx_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 100 || active !== 1'b1) begin
            bad++;
            $display("FAIL single_done waited=%0d active=%b (want done seen, active 1)", n, active);
        end
        @(negedge clk);
        #1;
        total++;
        if (active !== 1'b0 || tx_p_data !== 8'hA5) begin
            bad++;
            $display("FAIL single_after active=%b data=%h (want 0,a5)", active, tx_p_data);
        end
    endtask

    task automatic test_fairness;
        int order[5] = '{0, 1, 2, 3, 0};
        int seen = 0;
        int n = 0;
        do_reset();
        req_data = 32'h13121110;
        req_valid = '1;
        while (seen < 5 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
            if (tx_data_valid) begin
                total++;
                if (grant_id !== 2'(order[seen]) || tx_p_data !== W'(8'h10 + order[seen])) begin
                    bad++;
                    $display("FAIL fair_order frame=%0d gid=%0d data=%h want gid=%0d data=%h",
                             seen, grant_id, tx_p_data, order[seen], 8'h10 + order[seen]);
                end
                seen++;
            end
        end
        total++;
        if (seen < 5) begin
            bad++;
            $display("FAIL fair_timeout frames=%0d want=5", seen);
        end
        req_valid = '0;
    endtask

    task automatic test_random_traffic;
        logic           idle = 1'b1;
        logic           load_due = 1'b0;
        logic [N-1:0]   exp_ready;
        logic [W-1:0]   exp_byte = '0;
        logic [1:0]     exp_gid = '0;
        int             last = N - 1;
        int             e;
        do_reset();
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            req_data = $urandom;
            #1;
            e = (idle && |req_valid) ? rr_pick(req_valid, last) : -1;
            exp_ready = '0;
            if (e >= 0) exp_ready[e] = 1'b1;
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL rand_ready cyc=%0d valid=%b got=%b want=%b", c, req_valid, req_ready, exp_ready);
            end
            total++;
            if (tx_data_valid !== load_due || active !== !idle) begin
                bad++;
                $display("FAIL rand_ctrl cyc=%0d dv=%b active=%b want dv=%b active=%b",
                         c, tx_data_valid, active, load_due, !idle);
            end
            total++;
            if (tx_p_data !== exp_byte || grant_id !== exp_gid) begin
                bad++;
                $display("FAIL rand_data cyc=%0d data=%h gid=%0d want data=%h gid=%0d",
                         c, tx_p_data, grant_id, exp_byte, exp_gid);
            end
            load_due = e >= 0;
            if (e >= 0) begin
                exp_byte = req_data[e*W +: W];
                exp_gid = 2'(e);
                last = e;
                idle = 1'b0;
            end
            if (tx_done) idle = 1'b1;
        end
        req_valid = '0;
    endtask

    task automatic test_short_frame;
        do_reset();
        xmode = 2'd2;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL short_ready got=%b want=0001", req_ready);
        end
        @(negedge clk);
        #1;
        req_valid = '0;
        total++;
        if (tx_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL short_load dv=%b want=1", tx_data_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if (active !== 1'b1 || tx_busy !== 1'b1 || tx_done !== 1'b1) begin
            bad++;
            $display("FAIL short_wait active=%b busy=%b done=%b want 1,1,1", active, tx_busy, tx_done);
        end
        @(negedge clk);
        #1;
        total++;
        if (active !== 1'b0 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL short_done_wins active=%b err=%b want 0,0", active, err_timeout);
        end
        xmode = 2'd0;
    endtask

    task automatic test_timeout;
        do_reset();
        xmode = 2'd1;
        for (int pass = 0; pass < 2; pass++) begin
            err_clr = pass == 1;
            req_valid = 4'b0100;
            @(negedge clk);
            #1;
            req_valid = '0;
            total++;
            if (tx_data_valid !== 1'b1) begin
                bad++;
                $display("FAIL to_load pass=%0d dv=%b want=1", pass, tx_data_valid);
            end
            for (int i = 1; i <= TO; i++) begin
                @(negedge clk);
                #1;
                total++;
                if (err_timeout !== 1'b0 || active !== 1'b1) begin
                    bad++;
                    $display("FAIL to_wait pass=%0d cyc=%0d err=%b active=%b want 0,1", pass, i, err_timeout, active);
                end
            end
            @(negedge clk);
            #1;
            total++;
            if (err_timeout !== 1'b1 || active !== 1'b0) begin
                bad++;
                $display("FAIL to_fire pass=%0d err=%b active=%b want 1,0", pass, err_timeout, active);
            end
            if (pass == 0) begin
                repeat (3) @(negedge clk);
                #1;
                total++;
                if (err_timeout !== 1'b1) begin
                    bad++;
                    $display("FAIL to_sticky err=%b want=1", err_timeout);
                end
                err_clr = 1'b1;
            end
            @(negedge clk);
            #1;
            err_clr = 1'b0;
            total++;
            if (err_timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_clear pass=%0d err=%b want=0", pass, err_timeout);
            end
        end
        xmode = 2'd0;
    endtask

    task automatic test_mid_frame_reset;
        do_reset();
        req_data = $urandom;
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL mid_ready got=%b want=0100", req_ready);
        end
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== '0 || tx_data_valid !== 1'b0 || tx_p_data !== '0 || grant_id !== '0 ||
            active !== 1'b0 || err_timeout !== 1'b0 || tx_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset ready=%b dv=%b data=%h gid=%0d active=%b err=%b tx_out=%b want all reset",
                     req_ready, tx_data_valid, tx_p_data, grant_id, active, err_timeout, tx_out);
        end
        @(negedge clk);
        req_valid = '1;
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_regrant got=%b want=0001", req_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (tx_data_valid !== 1'b1 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_load dv=%b gid=%0d want 1,0", tx_data_valid, grant_id);
        end
        rst = 1'b0;
        #1;
        total++;
        if (tx_data_valid !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL load_reset dv=%b active=%b want 0,0", tx_data_valid, active);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL load_reset_regrant got=%b want=0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back;
        int  loads = 0;
        int  cyc = 0;
        int  last_done = -1;
        logic pend = 1'b0;
        do_reset();
        req_data = $urandom;
        req_data[31:24] = 8'd0;
        req_valid = 4'b1000;
        while (loads < 256 && cyc < 12000) begin
            if (pend) req_data[31:24] = req_data[31:24] + 8'd1;
            #1;
            if (tx_data_valid) begin
                total++;
                if (tx_p_data !== 8'(loads) || grant_id !== 2'd3) begin
                    bad++;
                    $display("FAIL sweep_byte n=%0d data=%h gid=%0d want data=%h gid=3", loads, tx_p_data, grant_id, 8'(loads));
                end
                if (last_done >= 0) begin
                    total++;
                    if (cyc - last_done != 2) begin
                        bad++;
                        $display("FAIL sweep_gap n=%0d gap=%0d want=2", loads, cyc - last_done);
                    end
                end
                loads++;
            end
            if (tx_done) last_done = cyc;
            pend = req_ready[3];
            @(negedge clk);
            cyc++;
        end
        total++;
        if (loads < 256) begin
            bad++;
            $display("FAIL sweep_timeout loads=%0d want=256", loads);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fairness();
        test_random_traffic();
        test_short_frame();
        test_timeout();
        test_mid_frame_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
